// File: rtl/ball_move_scheduler.sv
// ----------------------------------------------------------------------------
// ball_move_scheduler
//   Produces the Ball datapath's 4-bit movement pulses. Two requesters are
//   arbitrated: debounced pushbuttons (priority; press + auto-repeat) and the
//   accelerometer tilt path (rate-proportional steps via per-axis accumulators).
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   btn_r/l/d/u  debounced buttons
//   accel_en     enables the tilt requester
//   accelX/Y     unsigned 9-bit accelerometer readings (ACC_CENTER = level)
//   movement     one-cycle pulses [3]=right [2]=left [1]=down [0]=up
//   active_src   00 IDLE, 01 BTN, 10 ACC
//   step_count   cycles with movement != 0, wrapping
//
// Configuration macro: BALL_SCHED_DIAG_EN
//   defined   : X and Y steps due together are issued in one cycle.
//   undefined : X issued first, Y deferred one cycle in a one-deep pending
//               register; the deferred Y is dropped if the source is left.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module ball_move_scheduler #(
    parameter int unsigned TICK_DIV    = 32'd10_000_000,
    parameter int unsigned ACC_DIV     = 32'd1_000_000,
    parameter int unsigned ACC_CENTER  = 32'd256,
    parameter int unsigned DEAD_ZONE   = 32'd16,
    parameter int unsigned STEP_THRESH = 32'd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_r,
    input  logic        btn_l,
    input  logic        btn_d,
    input  logic        btn_u,
    input  logic        accel_en,
    input  logic [8:0]  accelX,
    input  logic [8:0]  accelY,
    output logic [3:0]  movement,
    output logic [1:0]  active_src,
    output logic [15:0] step_count
);

    localparam int unsigned TICK_W = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
    localparam int unsigned ADIV_W = (ACC_DIV > 32'd1) ? $clog2(ACC_DIV) : 32'd1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 32'd1);
    localparam logic [ADIV_W-1:0] ADIV_LAST = ADIV_W'(ACC_DIV - 32'd1);
    localparam logic [11:0]       THRESH12  = 12'(STEP_THRESH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BTN  = 2'b01,
        S_ACC  = 2'b10
    } state_t;

    // Signed tilt relative to the level reading.
    function automatic logic [9:0] f_tilt(input logic [8:0] rd);
        return {1'b0, rd} - 10'(ACC_CENTER);
    endfunction

    // Magnitude beyond the dead zone; zero inside it.
    function automatic logic [9:0] f_eff(input logic [9:0] tilt);
        logic [9:0] mag;
        mag = tilt[9] ? (10'd0 - tilt) : tilt;
        if (mag > 10'(DEAD_ZONE)) begin
            return mag - 10'(DEAD_ZONE);
        end else begin
            return 10'd0;
        end
    endfunction

    // 12-bit saturating accumulate.
    function automatic logic [11:0] f_sat_add(input logic [11:0] acc, input logic [9:0] eff);
        logic [12:0] sum;
        sum = {1'b0, acc} + {3'b000, eff};
        return sum[12] ? 12'hFFF : sum[11:0];
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_btn_q;
    logic [TICK_W-1:0]   r_tick;
    logic [ADIV_W-1:0]   r_div;
    logic [11:0]         r_x_acc;
    logic [11:0]         r_y_acc;
    logic                r_x_sgn;
    logic                r_y_sgn;
    logic [3:0]          r_move;
    logic [15:0]         r_step_cnt;

    logic [3:0]          w_btn_vec;
    logic [3:0]          w_btn_rise;
    logic                w_any_btn;
    logic                w_any_rise;
    logic                w_btn_active;
    logic                w_tick_hit;
    logic [3:0]          w_btn_raw;
    logic [3:0]          w_btn_pulse;

    logic [9:0]          w_x_tilt;
    logic [9:0]          w_y_tilt;
    logic [9:0]          w_x_eff;
    logic [9:0]          w_y_eff;
    logic [11:0]         w_x_base;
    logic [11:0]         w_y_base;
    logic [11:0]         w_x_sum;
    logic [11:0]         w_y_sum;
    logic                w_x_step;
    logic                w_y_step;
    logic [11:0]         w_x_acc_nxt;
    logic [11:0]         w_y_acc_nxt;
    logic                w_acc_stay;
    logic                w_sample;
    logic [3:0]          w_acc_pulse;

    logic [3:0]          w_new;
    logic [3:0]          w_move_nxt;

    assign w_btn_vec  = {btn_r, btn_l, btn_d, btn_u};
    assign w_btn_rise = w_btn_vec & ~r_btn_q;
    assign w_any_btn  = |w_btn_vec;
    assign w_any_rise = |w_btn_rise;

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbiter next-state: buttons pre-empt tilt; BTN always exits via IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_btn) begin
                    w_next_state = S_BTN;
                end else if (accel_en) begin
                    w_next_state = S_ACC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BTN: begin
                if (!w_any_btn) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_BTN;
                end
            end
            S_ACC: begin
                if (w_any_rise) begin
                    w_next_state = S_BTN;
                end else if (!accel_en) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_ACC;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // The button path also fires on the edge that enters BTN, so the first
    // press pulse is not delayed by the state change.
    assign w_btn_active = (w_next_state == S_BTN);
    assign w_tick_hit   = (r_state == S_BTN) && (r_tick == TICK_LAST);

    // Button pulses: an edge pulses only the rising buttons; a repeat tick
    // pulses every held button. Opposing held buttons cancel their axis.
    always_comb begin
        w_btn_raw   = 4'b0000;
        w_btn_pulse = 4'b0000;
        if (!w_btn_active) begin
            w_btn_raw = 4'b0000;
        end else if (w_any_rise) begin
            w_btn_raw = w_btn_rise;
        end else if (w_tick_hit) begin
            w_btn_raw = w_btn_vec;
        end else begin
            w_btn_raw = 4'b0000;
        end
        if (btn_r && btn_l) begin
            w_btn_pulse[3:2] = 2'b00;
        end else begin
            w_btn_pulse[3:2] = w_btn_raw[3:2];
        end
        if (btn_d && btn_u) begin
            w_btn_pulse[1:0] = 2'b00;
        end else begin
            w_btn_pulse[1:0] = w_btn_raw[1:0];
        end
    end

    // Button edge history and auto-repeat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_q <= 4'b0000;
            r_tick  <= {TICK_W{1'b0}};
        end else begin
            r_btn_q <= w_btn_vec;
            if (!w_btn_active || w_any_rise || w_tick_hit) begin
                r_tick <= {TICK_W{1'b0}};
            end else begin
                r_tick <= r_tick + TICK_W'(32'd1);
            end
        end
    end

    // Per-axis tilt accumulation. A sign flip or a level reading discards
    // whatever was accumulated before adding this sample.
    assign w_x_tilt    = f_tilt(accelX);
    assign w_y_tilt    = f_tilt(accelY);
    assign w_x_eff     = f_eff(w_x_tilt);
    assign w_y_eff     = f_eff(w_y_tilt);
    assign w_x_base    = ((w_x_eff == 10'd0) || (w_x_tilt[9] != r_x_sgn)) ? 12'd0 : r_x_acc;
    assign w_y_base    = ((w_y_eff == 10'd0) || (w_y_tilt[9] != r_y_sgn)) ? 12'd0 : r_y_acc;
    assign w_x_sum     = f_sat_add(w_x_base, w_x_eff);
    assign w_y_sum     = f_sat_add(w_y_base, w_y_eff);
    assign w_x_step    = (w_x_sum >= THRESH12);
    assign w_y_step    = (w_y_sum >= THRESH12);
    assign w_x_acc_nxt = w_x_step ? (w_x_sum - THRESH12) : w_x_sum;
    assign w_y_acc_nxt = w_y_step ? (w_y_sum - THRESH12) : w_y_sum;

    assign w_acc_stay  = (r_state == S_ACC) && (w_next_state == S_ACC);
    assign w_sample    = w_acc_stay && (r_div == ADIV_LAST);
    // Positive X tilt = right, positive Y tilt = down.
    assign w_acc_pulse = w_sample ? {w_x_step & ~w_x_tilt[9], w_x_step & w_x_tilt[9],
                                     w_y_step & ~w_y_tilt[9], w_y_step & w_y_tilt[9]}
                                  : 4'b0000;

    // Sample divider and accumulators; everything restarts whenever ACC is left.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= {ADIV_W{1'b0}};
            r_x_acc <= 12'd0;
            r_y_acc <= 12'd0;
            r_x_sgn <= 1'b0;
            r_y_sgn <= 1'b0;
        end else if (!w_acc_stay) begin
            r_div   <= {ADIV_W{1'b0}};
            r_x_acc <= 12'd0;
            r_y_acc <= 12'd0;
            r_x_sgn <= 1'b0;
            r_y_sgn <= 1'b0;
        end else if (w_sample) begin
            r_div   <= {ADIV_W{1'b0}};
            r_x_acc <= w_x_acc_nxt;
            r_y_acc <= w_y_acc_nxt;
            r_x_sgn <= w_x_tilt[9];
            r_y_sgn <= w_y_tilt[9];
        end else begin
            r_div   <= r_div + ADIV_W'(32'd1);
        end
    end

    // Only one requester is live in any state, so the pulse sets never overlap.
    assign w_new = w_btn_pulse | w_acc_pulse;

`ifdef BALL_SCHED_DIAG_EN
    assign w_move_nxt = w_new;
`else
    logic [1:0] r_pend;
    state_t     r_pend_src;
    logic [1:0] w_pend_nxt;
    state_t     w_pend_src_nxt;
    logic       w_pend_ok;

    assign w_pend_ok = (r_pend != 2'b00) && (w_next_state == r_pend_src);

    // Axis serialisation: X goes first, Y waits one cycle. A fresh request
    // from the same source in the deferred-issue cycle is absorbed; both
    // requesters normally space their steps further apart than that.
    always_comb begin
        w_move_nxt     = 4'b0000;
        w_pend_nxt     = 2'b00;
        w_pend_src_nxt = r_pend_src;
        if (w_pend_ok) begin
            w_move_nxt = {2'b00, r_pend};
        end else if ((|w_new[3:2]) && (|w_new[1:0])) begin
            w_move_nxt     = {w_new[3:2], 2'b00};
            w_pend_nxt     = w_new[1:0];
            w_pend_src_nxt = w_next_state;
        end else begin
            w_move_nxt = w_new;
        end
    end

    // Deferred Y step register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend     <= 2'b00;
            r_pend_src <= S_IDLE;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_src <= w_pend_src_nxt;
        end
    end
`endif

    // Registered outputs and issued-step counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_move     <= 4'b0000;
            r_step_cnt <= 16'd0;
        end else begin
            r_move <= w_move_nxt;
            if (w_move_nxt != 4'b0000) begin
                r_step_cnt <= r_step_cnt + 16'd1;
            end else begin
                r_step_cnt <= r_step_cnt;
            end
        end
    end

    assign movement   = r_move;
    assign active_src = r_state;
    assign step_count = r_step_cnt;

endmodule

// File: tb/tb_ball_move_scheduler.sv
`timescale 1ns/1ps
module tb_ball_move_scheduler;

    localparam logic [1:0] SRC_IDLE = 2'b00;
    localparam logic [1:0] SRC_BTN  = 2'b01;
    localparam logic [1:0] SRC_ACC  = 2'b10;
    localparam logic [8:0] LEVEL    = 9'd256;

    typedef struct packed {
        logic [3:0]  mv;
        logic [1:0]  src;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        btn_r, btn_l, btn_d, btn_u;
    logic        accel_en;
    logic [8:0]  accelX, accelY;
    logic [3:0]  movement;
    logic [1:0]  active_src;
    logic [15:0] step_count;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] exp_steps;
    logic [3:0]  em;
    int          vectors;
    int          miscompares;

    ball_move_scheduler #(
        .TICK_DIV    (32'd10),
        .ACC_DIV     (32'd4),
        .ACC_CENTER  (32'd256),
        .DEAD_ZONE   (32'd4),
        .STEP_THRESH (32'd32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_r      (btn_r),
        .btn_l      (btn_l),
        .btn_d      (btn_d),
        .btn_u      (btn_u),
        .accel_en   (accel_en),
        .accelX     (accelX),
        .accelY     (accelY),
        .movement   (movement),
        .active_src (active_src),
        .step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and queue the output expected after the next edge.
    task automatic drive(input logic [3:0] btn, input logic en, input logic [8:0] ax,
                         input logic [8:0] ay, input logic [3:0] emv, input logic [1:0] esrc);
        exp_t e;
        {btn_r, btn_l, btn_d, btn_u} = btn;
        accel_en = en;
        accelX   = ax;
        accelY   = ay;
        if (emv != 4'b0000) exp_steps = exp_steps + 16'd1;
        e.mv  = emv;
        e.src = esrc;
        e.cnt = exp_steps;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pop at the edge, compare mid-cycle.
    always @(posedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            @(negedge clk);
            chk_vec("movement",   {28'd0, movement},   {28'd0, mon_e.mv});
            chk_vec("active_src", {30'd0, active_src}, {30'd0, mon_e.src});
            chk_vec("step_count", {16'd0, step_count}, {16'd0, mon_e.cnt});
            chk_vec("opposing",   {31'd0, (movement[3] & movement[2]) | (movement[1] & movement[0])}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_steps   = 16'd0;
        reset       = 1'b0;
        {btn_r, btn_l, btn_d, btn_u} = 4'b0000;
        accel_en    = 1'b0;
        accelX      = LEVEL;
        accelY      = LEVEL;
        repeat (2) @(posedge clk);
        #1;
        chk_vec("rst_movement",   {28'd0, movement},   32'd0);
        chk_vec("rst_active_src", {30'd0, active_src}, 32'd0);
        chk_vec("rst_step_count", {16'd0, step_count}, 32'd0);
        reset = 1'b1;

        for (int c = 0; c < 3; c++) drive(4'b0000, 1'b0, LEVEL, LEVEL, 4'b0000, SRC_IDLE);

        // Press-and-hold right: pulses at edge+1 then every 10 clocks.
        for (int c = 0; c < 35; c++)
            drive(4'b1000, 1'b0, LEVEL, LEVEL, (c % 10 == 0) ? 4'b1000 : 4'b0000, SRC_BTN);
        drive(4'b0000, 1'b0, LEVEL, LEVEL, 4'b0000, SRC_IDLE);
        for (int c = 0; c < 2; c++) drive(4'b0000, 1'b0, LEVEL, LEVEL, 4'b0000, SRC_IDLE);
        chk_vec("hold35_steps", {16'd0, step_count}, 32'd4);

        // Reset while a repeat pulse is on the output, button kept held.
        for (int c = 0; c < 11; c++)
            drive(4'b1000, 1'b0, LEVEL, LEVEL, (c % 10 == 0) ? 4'b1000 : 4'b0000, SRC_BTN);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_vec("async_rst_movement",   {28'd0, movement},   32'd0);
        chk_vec("async_rst_active_src", {30'd0, active_src}, 32'd0);
        chk_vec("async_rst_step_count", {16'd0, step_count}, 32'd0);
        exp_steps = 16'd0;
        @(posedge clk);
        #1;
        chk_vec("rst_held_movement", {28'd0, movement}, 32'd0);
        reset = 1'b1;
        for (int c = 0; c < 12; c++)
            drive(4'b1000, 1'b0, LEVEL, LEVEL, (c % 10 == 0) ? 4'b1000 : 4'b0000, SRC_BTN);
        drive(4'b0000, 1'b0, LEVEL, LEVEL, 4'b0000, SRC_IDLE);
        drive(4'b0000, 1'b0, LEVEL, LEVEL, 4'b0000, SRC_IDLE);

        // Left+right cancel; adding up restarts the repeat counter.
        for (int c = 0; c < 15; c++) drive(4'b1100, 1'b0, LEVEL, LEVEL, 4'b0000, SRC_BTN);
        for (int c = 0; c < 25; c++)
            drive(4'b1101, 1'b0, LEVEL, LEVEL, (c % 10 == 0) ? 4'b0001 : 4'b0000, SRC_BTN);
        drive(4'b0000, 1'b0, LEVEL, LEVEL, 4'b0000, SRC_IDLE);
        drive(4'b0000, 1'b0, LEVEL, LEVEL, 4'b0000, SRC_IDLE);

        // Tilt right, eff 16: one step every second sample (8 clocks).
        for (int c = 0; c < 38; c++)
            drive(4'b0000, 1'b1, 9'd276, LEVEL, ((c % 8 == 0) && (c > 0)) ? 4'b1000 : 4'b0000, SRC_ACC);

        // Button pre-empts tilt with acc > 0; tilt restarts from empty afterwards.
        drive(4'b0010, 1'b1, 9'd276, LEVEL, 4'b0010, SRC_BTN);
        for (int c = 0; c < 2; c++) drive(4'b0010, 1'b1, 9'd276, LEVEL, 4'b0000, SRC_BTN);
        drive(4'b0000, 1'b1, 9'd276, LEVEL, 4'b0000, SRC_IDLE);
        for (int c = 0; c < 10; c++)
            drive(4'b0000, 1'b1, 9'd276, LEVEL, (c == 8) ? 4'b1000 : 4'b0000, SRC_ACC);
        drive(4'b0000, 1'b0, 9'd276, LEVEL, 4'b0000, SRC_IDLE);

        // Diagonal tilt down-right, eff 40 per axis; leave ACC with a Y deferred.
        for (int c = 0; c < 9; c++) begin
`ifdef BALL_SCHED_DIAG_EN
            em = ((c == 4) || (c == 8)) ? 4'b1010 : 4'b0000;
`else
            em = ((c == 4) || (c == 8)) ? 4'b1000 : ((c == 5) ? 4'b0010 : 4'b0000);
`endif
            drive(4'b0000, 1'b1, 9'd300, 9'd300, em, SRC_ACC);
        end
        drive(4'b0000, 1'b0, 9'd300, 9'd300, 4'b0000, SRC_IDLE);

        // Diagonal tilt up-left with unequal rates.
        for (int c = 0; c < 14; c++) begin
`ifdef BALL_SCHED_DIAG_EN
            em = (c == 8) ? 4'b0101 : ((c == 12) ? 4'b0001 : 4'b0000);
`else
            em = (c == 8) ? 4'b0100 : (((c == 9) || (c == 12)) ? 4'b0001 : 4'b0000);
`endif
            drive(4'b0000, 1'b1, 9'd236, 9'd226, em, SRC_ACC);
        end
        drive(4'b0000, 1'b0, 9'd236, 9'd226, 4'b0000, SRC_IDLE);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
